// File: rtl/alu_pkg.sv
// Shared decode constants and the registered execute-operand bundle type
// for the ALU issue stage.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [3:0]        op;
    logic [4:0]        rd;
    logic              we;
    logic              illegal;
  } bundle_t;

  localparam int BUNDLE_W = 2 * DATA_W + 4 + 5 + 1 + 1;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I ALU-class decode: operand select, ALU op, rd, write
// enable and illegal-encoding flag.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter bit SUPPRESS_X0_WE = 1'b1
) (
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output bundle_t     bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];
  assign rd     = instr[11:7];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    bundle    = '0;
    legal     = 1'b0;
    bundle.rd = rd;
    case (opcode)
      OPC_OP: begin
        legal     = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        bundle.a  = rs1_data;
        bundle.b  = rs2_data;
        bundle.op = {instr[30], funct3};
      end
      OPC_OP_IMM: begin
        legal     = 1'b1;
        bundle.a  = rs1_data;
        bundle.b  = imm_i;
        bundle.op = {1'b0, funct3};
        // Shift immediates carry funct7 in imm[11:5]; only the shamt reaches the ALU.
        if (funct3 == 3'b001) begin
          legal    = (funct7 == F7_BASE);
          bundle.b = shamt;
        end else if (funct3 == 3'b101) begin
          legal     = (funct7 == F7_BASE) || (funct7 == F7_ALT);
          bundle.b  = shamt;
          bundle.op = {instr[30], funct3};
        end
      end
      OPC_LUI: begin
        legal    = 1'b1;
        bundle.b = imm_u;
      end
      OPC_AUIPC: begin
        legal    = 1'b1;
        bundle.a = pc;
        bundle.b = imm_u;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      bundle.a  = '0;
      bundle.b  = '0;
      bundle.op = ALU_ADD;
    end
    bundle.illegal = !legal;
    bundle.we      = legal && !(SUPPRESS_X0_WE && (rd == 5'd0));
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register for the ALU with valid/ready on both sides and flush.
// Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer with registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter bit SUPPRESS_X0_WE = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] a_out,
  output logic [XLEN-1:0] b_out,
  output logic [3:0]      alu_op,
  output logic [4:0]      rd_addr,
  output logic            rd_we,
  output logic            illegal
);

  if (XLEN != DATA_W) begin : g_xlen_check
    $error("alu_issue_stage supports XLEN=32 only");
  end

  bundle_t dec_bundle;
  bundle_t main_reg;
  logic    main_valid_reg;
  logic    accept;

  alu_issue_decode #(
    .SUPPRESS_X0_WE(SUPPRESS_X0_WE)
  ) u_decode (
    .instr    (instr),
    .pc       (pc),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .bundle   (dec_bundle)
  );

  assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  bundle_t skid_reg;
  logic    skid_valid_reg;

  // in_ready depends only on state, so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      main_reg       <= '0;
      skid_reg       <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (!main_valid_reg || out_ready) begin
      if (skid_valid_reg) begin
        main_reg       <= skid_reg;
        main_valid_reg <= 1'b1;
        skid_valid_reg <= 1'b0;
      end else if (accept) begin
        main_reg       <= dec_bundle;
        main_valid_reg <= 1'b1;
      end else begin
        main_valid_reg <= 1'b0;
      end
    end else if (accept) begin
      skid_reg       <= dec_bundle;
      skid_valid_reg <= 1'b1;
    end
  end
`else
  assign in_ready = !main_valid_reg || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_reg <= 1'b0;
      main_reg       <= '0;
    end else if (flush) begin
      main_valid_reg <= 1'b0;
    end else if (accept) begin
      main_reg       <= dec_bundle;
      main_valid_reg <= 1'b1;
    end else if (out_ready) begin
      main_valid_reg <= 1'b0;
    end
  end
`endif

  assign out_valid = main_valid_reg;
  assign a_out     = main_reg.a;
  assign b_out     = main_reg.b;
  assign alu_op    = main_reg.op;
  assign rd_addr   = main_reg.rd;
  assign rd_we     = main_reg.we;
  assign illegal   = main_reg.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: decode vectors, stall,
// 16-instruction stream ordering, flush and mid-stream reset.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] a_out;
  logic [31:0] b_out;
  logic [3:0]  alu_op;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  int total = 0;
  int bad   = 0;
  int sent;
  int recv;
  logic [31:0] hold_a;
  logic [31:0] hold_b;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a_out     (a_out),
    .b_out     (b_out),
    .alu_op    (alu_op),
    .rd_addr   (rd_addr),
    .rd_we     (rd_we),
    .illegal   (illegal)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] r1, input logic [31:0] r2);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    instr     = i;
    pc        = p;
    rs1_data  = r1;
    rs2_data  = r2;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] rd,
                         input logic we, input logic ill);
    chk({tag, ".valid"}, out_valid, 1'b1);
    chk({tag, ".a"}, a_out, a);
    chk({tag, ".b"}, b_out, b);
    chk({tag, ".op"}, alu_op, op);
    chk({tag, ".rd"}, rd_addr, rd);
    chk({tag, ".we"}, rd_we, we);
    chk({tag, ".illegal"}, illegal, ill);
    $display("txn %s: a=%h b=%h op=%h rd=%0d we=%0d ill=%0d", tag, a_out, b_out, alu_op,
             rd_addr, rd_we, illegal);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    instr = 32'h0; pc = 32'h0; rs1_data = 32'h0; rs2_data = 32'h0;
    tick();
    tick();
    chk("rst.valid", out_valid, 1'b0);
    chk("rst.a", a_out, 32'h0);
    chk("rst.b", b_out, 32'h0);
    chk("rst.op", alu_op, 4'h0);
    chk("rst.rd", rd_addr, 5'd0);
    chk("rst.we", rd_we, 1'b0);
    chk("rst.illegal", illegal, 1'b0);
    chk("rst.in_ready", in_ready, 1'b1);
    rst = 1'b0;
    tick();

    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk_out("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
    issue(32'h402081B3, 32'h0, 32'd5, 32'd7);
    chk_out("sub", 32'd5, 32'd7, 4'b1000, 5'd3, 1'b1, 1'b0);
    issue(32'h40335293, 32'h0, 32'h80000000, 32'd9);
    chk_out("srai", 32'h80000000, 32'd3, 4'b1101, 5'd5, 1'b1, 1'b0);
    issue(32'h123450B7, 32'h0, 32'd11, 32'd12);
    chk_out("lui", 32'h0, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0);
    issue(32'h12345097, 32'h100, 32'd11, 32'd12);
    chk_out("auipc", 32'h100, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0);
    issue(32'h40010093, 32'h0, 32'd20, 32'd0);
    chk_out("addi_b30", 32'd20, 32'h400, 4'b0000, 5'd1, 1'b1, 1'b0);
    issue(32'hFFF10093, 32'h0, 32'd20, 32'd0);
    chk_out("addi_neg", 32'd20, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
    issue(32'h00208033, 32'h0, 32'd5, 32'd7);
    chk_out("add_x0", 32'd5, 32'd7, 4'b0000, 5'd0, 1'b0, 1'b0);

    issue(32'h022081B3, 32'h0, 32'd5, 32'd7);
    chk("mul.valid", out_valid, 1'b1);
    chk("mul.illegal", illegal, 1'b1);
    chk("mul.we", rd_we, 1'b0);
    issue(32'h402091B3, 32'h0, 32'd5, 32'd7);
    chk("op_f7alt_sll.illegal", illegal, 1'b1);
    issue(32'h40011093, 32'h0, 32'd5, 32'd7);
    chk("slli_bad.illegal", illegal, 1'b1);
    issue(32'h00012083, 32'h0, 32'd5, 32'd7);
    chk_out("load", 32'h0, 32'h0, 4'b0000, 5'd1, 1'b0, 1'b1);
    tick();
    chk("drain.valid", out_valid, 1'b0);

    // 16-instruction ADDI stream with a 3-cycle consumer stall
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 80 && recv < 16; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      in_valid  = (sent < 16);
      instr     = {sent[11:0], 5'd1, 3'b000, 5'd2, 7'b0010011};
      rs1_data  = 32'h100 + sent;
      #1;
      if (cyc == 4) begin
        hold_a = a_out;
        hold_b = b_out;
        chk("stall.valid", out_valid, 1'b1);
      end
      if (cyc == 5 || cyc == 6) begin
        chk("stall.a_stable", a_out, hold_a);
        chk("stall.b_stable", b_out, hold_b);
      end
      if (cyc == 6) chk("stall.in_ready", in_ready, 1'b0);
      if (out_valid && out_ready) begin
        chk("stream.b", b_out, recv);
        chk("stream.a", a_out, 32'h100 + recv);
        $display("txn stream %0d: a=%h b=%h", recv, a_out, b_out);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    chk("stream.count", recv, 32'd16);
    out_ready = 1'b1;
    tick();
    tick();

    // flush while stalled with a same-cycle incoming instruction
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h002081B3;
    rs1_data  = 32'd1;
    rs2_data  = 32'd2;
    tick();
    in_valid = 1'b0;
    tick();
    chk("flush.pre_valid", out_valid, 1'b1);
    flush    = 1'b1;
    in_valid = 1'b1;
    instr    = 32'h7AB10093;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush.valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("flush.gone", out_valid, 1'b0);
    end
    issue(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk_out("post_flush", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
    tick();

    // reset mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = 32'h402081B3;
    tick();
    chk("prerst.valid", out_valid, 1'b1);
    rst = 1'b1;
    tick();
    chk("midrst.valid", out_valid, 1'b0);
    chk("midrst.a", a_out, 32'h0);
    chk("midrst.b", b_out, 32'h0);
    chk("midrst.op", alu_op, 4'h0);
    chk("midrst.rd", rd_addr, 5'd0);
    chk("midrst.we", rd_we, 1'b0);
    chk("midrst.illegal", illegal, 1'b0);
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
